int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC1, default 32'h0000_0045, SHALL be the service address for level 1.
REQ-002 Parameter VEC2, default 32'h0000_0078, SHALL be the service address for level 2.
REQ-003 Parameter VEC3, default 32'h0000_00AB, SHALL be the service address for level 3.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 irq  in  3  raw request lines; bit i-1 is level i; synchronous to clk; level 3 has the highest priority.
REQ-007 mask_we  in  1  write strobe for mask register.
REQ-008 mask_wdata  in  3  new mask value; 1 = level blocked.
REQ-009 ie_set  in  1  global interrupt enable set strobe.
REQ-010 ie_clr  in  1  global interrupt enable clear strobe.
REQ-011 int_ack  in  1  CPU accepts the request at an instruction boundary.
REQ-012 int_ret  in  1  CPU return-from-interrupt strobe.
REQ-013 int_req  out  1  request to CPU; high only in state REQ.
REQ-014 vec_addr  out  32  registered service address of the selected level.
REQ-015 cur_level  out  2  highest in-service level; 0 = none.
REQ-016 pending  out  3  latched pending requests.
REQ-017 mask  out  3  current mask register.
REQ-018 ie  out  1  global enable.

Function
REQ-019 A pending bit SHALL set on a 0->1 transition of its irq bit (registered irq_prev), one cycle after the edge; a level held high SHALL NOT re-set the bit.
REQ-020 eligible = pending & ~mask; sel = index of highest eligible bit; fire = ie && eligible != 0 && sel > cur_level.
REQ-021 FSM states: IDLE, REQ; reset state IDLE.
REQ-022 IDLE -> REQ when fire; vec_addr loads vector(sel) on that same edge.
REQ-023 In REQ, sel and vec_addr SHALL re-evaluate every cycle, so a higher level arriving before ack replaces the lower one.
REQ-024 In REQ with fire false and int_ack low: return to IDLE; int_req drops next cycle; vec_addr holds.
REQ-025 In REQ with int_ack high: pending[sel] clears, in_service[sel] sets, ie clears, FSM -> IDLE; the vec_addr presented that cycle is the accepted one.
REQ-026 int_ack while in IDLE SHALL be ignored.
REQ-027 A new edge on the accepted level in the ack cycle SHALL leave pending set (set wins over clear).
REQ-028 int_ret SHALL clear the highest set in_service bit; with in_service == 0 it SHALL have no effect.
REQ-029 int_ret and int_ack in the same cycle: ret applies to the old in_service first, then ack sets its bit.
REQ-030 cur_level SHALL equal the index of the highest set in_service bit, registered, one cycle after the ack/ret edge.
REQ-031 ie: ie_clr or ack clears; ie_set alone sets; a clear from either source wins over ie_set.
REQ-032 mask_we loads mask_wdata next edge; masking a level in REQ withdraws it per REQ-023/024.
REQ-033 Minimum latency irq edge -> int_req high SHALL be 2 cycles (edge latch, then REQ).

Reset
REQ-034 On rst: pending, in_service, irq_prev, mask, ie, vec_addr, cur_level, int_req = 0; FSM IDLE; an ack/ret applied with rst SHALL be discarded.
REQ-035 rst asserted in REQ SHALL drop int_req immediately (asynchronously).

Verification
REQ-036 ie_set; irq=3'b001 pulse -> int_req high 2 cycles later, vec_addr 32'h45; ack -> cur_level 1, ie 0, pending 0.
REQ-037 ie=1, irq 3'b001 and 3'b100 same edge -> vec_addr 32'hAB; after ack pending 3'b001, cur_level 3.
REQ-038 Nesting: level 1 in service, ie_set, irq level 2 -> int_req, vec 32'h78, ack -> cur_level 2; int_ret -> cur_level 1; int_ret -> 0.
REQ-039 In REQ for level 1, mask_wdata 3'b001 with mask_we -> int_req low next cycle, pending stays 3'b001; unmask -> int_req returns.
REQ-040 Level 3 in service, irq level 2 with ie=1 -> no int_req; int_ret -> int_req high with vec 32'h78.
REQ-041 rst asserted mid-REQ -> int_req 0 immediately, all outputs 0 after release.

Source files
------------

// File: rtl/int_ctrl.sv
// Three-level prioritised interrupt controller with nesting.
// Edge-detected requests are latched as pending, filtered by mask, and the
// highest eligible level above the current in-service level is offered to
// the CPU together with its registered service address.
module int_ctrl #(
  parameter logic [31:0] VEC1 = 32'h0000_0045,
  parameter logic [31:0] VEC2 = 32'h0000_0078,
  parameter logic [31:0] VEC3 = 32'h0000_00AB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq,
  input  logic        mask_we,
  input  logic [2:0]  mask_wdata,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        int_ack,
  input  logic        int_ret,
  output logic        int_req,
  output logic [31:0] vec_addr,
  output logic [1:0]  cur_level,
  output logic [2:0]  pending,
  output logic [2:0]  mask,
  output logic        ie
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e      state_q, state_d;
  logic [2:0]  irq_prev_q;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  mask_q, mask_d;
  logic        ie_q, ie_d;
  logic [2:0]  in_service_q, in_service_d;
  logic [31:0] vec_addr_q, vec_addr_d;
  logic [1:0]  sel_q, sel_d;          // level whose vector is currently presented
  logic [1:0]  cur_level_q, cur_level_d;

  logic [2:0]  eligible;
  logic [1:0]  sel;
  logic        fire;
  logic        ack;

  // Index of the highest set bit, 0 when none is set.
  function automatic logic [1:0] highest(input logic [2:0] v);
    if (v[2])      highest = 2'd3;
    else if (v[1]) highest = 2'd2;
    else if (v[0]) highest = 2'd1;
    else           highest = 2'd0;
  endfunction

  // One-hot bit for a level; level 0 maps to no bit.
  function automatic logic [2:0] level_bit(input logic [1:0] lvl);
    unique case (lvl)
      2'd1:    level_bit = 3'b001;
      2'd2:    level_bit = 3'b010;
      2'd3:    level_bit = 3'b100;
      default: level_bit = 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] vector(input logic [1:0] lvl);
    unique case (lvl)
      2'd1:    vector = VEC1;
      2'd2:    vector = VEC2;
      2'd3:    vector = VEC3;
      default: vector = 32'h0;
    endcase
  endfunction

  // Arbitration: highest unmasked pending level that outranks the current one.
  always_comb begin
    eligible = pending_q & ~mask_q;
    sel      = highest(eligible);
    fire     = ie_q && (eligible != 3'b000) && (sel > cur_level_q);
    ack      = (state_q == StReq) && int_ack;
  end

  // FSM next state and the presented vector/level.
  always_comb begin
    state_d    = state_q;
    vec_addr_d = vec_addr_q;
    sel_d      = sel_q;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          state_d    = StReq;
          vec_addr_d = vector(sel);
          sel_d      = sel;
        end
      end
      StReq: begin
        if (int_ack) begin
          // Accept the level whose vector is on the bus this cycle.
          state_d = StIdle;
        end else if (fire) begin
          vec_addr_d = vector(sel);
          sel_d      = sel;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending, in-service, mask and enable updates.
  always_comb begin
    pending_d = pending_q;
    if (ack) pending_d = pending_d & ~level_bit(sel_q);
    // A fresh edge in the ack cycle must survive the clear.
    pending_d = pending_d | (irq & ~irq_prev_q);

    // Return retires the old top level before the ack adds the new one.
    in_service_d = in_service_q;
    if (int_ret) in_service_d = in_service_d & ~level_bit(highest(in_service_q));
    if (ack)     in_service_d = in_service_d | level_bit(sel_q);
    cur_level_d = highest(in_service_d);

    mask_d = mask_we ? mask_wdata : mask_q;

    ie_d = ie_q;
    if (ie_clr || ack) ie_d = 1'b0;
    else if (ie_set)   ie_d = 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      irq_prev_q   <= 3'b000;
      pending_q    <= 3'b000;
      mask_q       <= 3'b000;
      ie_q         <= 1'b0;
      in_service_q <= 3'b000;
      vec_addr_q   <= 32'h0;
      sel_q        <= 2'd0;
      cur_level_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ie_q         <= ie_d;
      in_service_q <= in_service_d;
      vec_addr_q   <= vec_addr_d;
      sel_q        <= sel_d;
      cur_level_q  <= cur_level_d;
    end
  end

  // Request is decoded from the state so reset removes it at once.
  always_comb begin
    int_req   = (state_q == StReq);
    vec_addr  = vec_addr_q;
    cur_level = cur_level_q;
    pending   = pending_q;
    mask      = mask_q;
    ie        = ie_q;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: priority, nesting, masking, ack/ret corner cases
// and asynchronous reset.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        ie_set;
  logic        ie_clr;
  logic        int_ack;
  logic        int_ret;
  logic        int_req;
  logic [31:0] vec_addr;
  logic [1:0]  cur_level;
  logic [2:0]  pending;
  logic [2:0]  mask;
  logic        ie;

  int n_checks = 0;
  int n_errors = 0;

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .vec_addr   (vec_addr),
    .cur_level  (cur_level),
    .pending    (pending),
    .mask       (mask),
    .ie         (ie)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; irq = 3'b000; mask_we = 1'b0; mask_wdata = 3'b000;
    ie_set = 1'b0; ie_clr = 1'b0; int_ack = 1'b1; int_ret = 1'b1;
    tick(); tick();
    int_ack = 1'b0; int_ret = 1'b0;
    check("rst_int_req",   32'(int_req),   32'd0);
    check("rst_vec",       vec_addr,       32'h0);
    check("rst_cur",       32'(cur_level), 32'd0);
    check("rst_pending",   32'(pending),   32'd0);
    check("rst_mask",      32'(mask),      32'd0);
    check("rst_ie",        32'(ie),        32'd0);
    rst = 1'b0;
    tick();

    // Single level 1 request.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    check("t1_ie",         32'(ie),        32'd1);
    irq = 3'b001; tick();
    check("t1_pend",       32'(pending),   32'b001);
    check("t1_noreq_yet",  32'(int_req),   32'd0);
    irq = 3'b000; tick();
    check("t1_req",        32'(int_req),   32'd1);
    check("t1_vec",        vec_addr,       32'h45);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t1_cur",        32'(cur_level), 32'd1);
    check("t1_ie_clr",     32'(ie),        32'd0);
    check("t1_pend_clr",   32'(pending),   32'd0);
    check("t1_req_drop",   32'(int_req),   32'd0);

    // Nesting level 2 over level 1, then unwind.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq = 3'b010; tick(); irq = 3'b000; tick();
    check("t2_req",        32'(int_req),   32'd1);
    check("t2_vec",        vec_addr,       32'h78);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t2_cur2",       32'(cur_level), 32'd2);
    int_ret = 1'b1; tick();
    check("t2_ret1",       32'(cur_level), 32'd1);
    tick();
    check("t2_ret0",       32'(cur_level), 32'd0);
    tick(); int_ret = 1'b0;
    check("t2_ret_none",   32'(cur_level), 32'd0);

    // Simultaneous levels 1 and 3: 3 wins.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq = 3'b101; tick(); irq = 3'b000; tick();
    check("t3_vec",        vec_addr,       32'hAB);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t3_pend",       32'(pending),   32'b001);
    check("t3_cur",        32'(cur_level), 32'd3);

    // Level 2 blocked under level 3 until return.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq = 3'b010; tick(); irq = 3'b000; tick(); tick();
    check("t4_blocked",    32'(int_req),   32'd0);
    check("t4_pend",       32'(pending),   32'b011);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check("t4_cur0",       32'(cur_level), 32'd0);
    tick();
    check("t4_req",        32'(int_req),   32'd1);
    check("t4_vec",        vec_addr,       32'h78);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t4_cur2",       32'(cur_level), 32'd2);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check("t4_ret",        32'(cur_level), 32'd0);

    // Mask withdraws a level 1 request; ack in IDLE ignored; unmask restores.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    tick();
    check("t5_req",        32'(int_req),   32'd1);
    check("t5_vec",        vec_addr,       32'h45);
    mask_we = 1'b1; mask_wdata = 3'b001; tick(); mask_we = 1'b0;
    check("t5_mask",       32'(mask),      32'b001);
    tick();
    check("t5_withdrawn",  32'(int_req),   32'd0);
    check("t5_pend_kept",  32'(pending),   32'b001);
    check("t5_vec_hold",   vec_addr,       32'h45);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t5_idle_ack_p", 32'(pending),   32'b001);
    check("t5_idle_ack_i", 32'(ie),        32'd1);
    check("t5_idle_ack_c", 32'(cur_level), 32'd0);
    mask_we = 1'b1; mask_wdata = 3'b000; tick(); mask_we = 1'b0;
    tick();
    check("t5_req_back",   32'(int_req),   32'd1);

    // Held level does not re-arm pending.
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("t6_cur1",       32'(cur_level), 32'd1);
    irq = 3'b100; tick();
    check("t6_pend3",      32'(pending),   32'b100);
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    tick();
    check("t6_vec",        vec_addr,       32'hAB);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick(); tick();
    check("t6_no_rearm",   32'(pending),   32'b000);
    check("t6_cur3",       32'(cur_level), 32'd3);
    irq = 3'b000;
    int_ret = 1'b1; tick(); tick(); int_ret = 1'b0;
    check("t6_unwind",     32'(cur_level), 32'd0);

    // New edge during ack keeps pending; ret+ack in one cycle.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq = 3'b010; tick(); irq = 3'b000; tick();
    check("t7_vec",        vec_addr,       32'h78);
    int_ack = 1'b1; irq = 3'b010; tick(); int_ack = 1'b0; irq = 3'b000;
    check("t7_set_wins",   32'(pending),   32'b010);
    check("t7_cur2",       32'(cur_level), 32'd2);
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq = 3'b100; tick(); irq = 3'b000; tick();
    check("t7_vec3",       vec_addr,       32'hAB);
    int_ack = 1'b1; int_ret = 1'b1; tick(); int_ack = 1'b0; int_ret = 1'b0;
    check("t7_retack_cur", 32'(cur_level), 32'd3);
    check("t7_retack_pnd", 32'(pending),   32'b010);
    int_ret = 1'b1; tick(); int_ret = 1'b0;
    check("t7_ret",        32'(cur_level), 32'd0);

    // Asynchronous reset in REQ.
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    tick();
    check("t8_req",        32'(int_req),   32'd1);
    rst = 1'b1; #1;
    check("t8_async_drop", 32'(int_req),   32'd0);
    tick(); rst = 1'b0; tick();
    check("t8_vec",        vec_addr,       32'h0);
    check("t8_cur",        32'(cur_level), 32'd0);
    check("t8_pend",       32'(pending),   32'd0);
    check("t8_mask",       32'(mask),      32'd0);
    check("t8_ie",         32'(ie),        32'd0);
    check("t8_req_off",    32'(int_req),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
